// File: rtl/led_dev_pkg.sv
// led_dev_pkg: display mode encodings shared by the LED status block
package led_dev_pkg;
  typedef enum logic [1:0] {
    LIVE   = 2'b00,
    STICKY = 2'b01,
    BLINK  = 2'b10,
    SCAN   = 2'b11
  } mode_t;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler, one-cycle tick on each wrap
module led_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_status_dev.sv
// led_status_dev: status flag capture with live/sticky/blink/scan LED display
module led_status_dev
  import led_dev_pkg::*;
#(
  parameter int N_FLAGS  = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FLAGS-1:0] flags,
  input  logic [1:0]         mode,
  input  logic               clr,
  output logic [N_FLAGS-1:0] LED,
  output logic               any_sticky
);
  logic [N_FLAGS-1:0] flags_q, sticky, ptr, ptr_next, led_next;
  logic               blink_phase, tick, scan_enter;
  mode_t              m, mode_q;
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign m = mode_t'(mode);
  // LED shows ptr_next so the reload on SCAN entry is visible on the same edge
  always_comb begin
    scan_enter = m == SCAN && mode_q != SCAN;
    ptr_next   = scan_enter ? N_FLAGS'(1)
               : (m == SCAN && tick) ? (ptr << 1) | (ptr >> (N_FLAGS - 1))
               : ptr;
    led_next   = m == LIVE   ? flags_q
               : m == STICKY ? sticky
               : m == BLINK  ? flags_q | (sticky & {N_FLAGS{blink_phase}})
               : ptr_next;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flags_q     <= '0;
      sticky      <= '0;
      blink_phase <= 1'b0;
      ptr         <= N_FLAGS'(1);
      mode_q      <= LIVE;
      LED         <= '0;
      any_sticky  <= 1'b0;
    end else begin
      flags_q     <= flags;
      sticky      <= (clr ? '0 : sticky) | flags_q;
      blink_phase <= blink_phase ^ tick;
      ptr         <= ptr_next;
      mode_q      <= m;
      LED         <= led_next;
      any_sticky  <= |sticky;
    end
endmodule

// File: tb/tb_led_status_dev.sv
// tb_led_status_dev: directed + random checks against a cycle-level behavioural model
module tb_led_status_dev;
  localparam int N  = 8;
  localparam int TD = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] flags = '0;
  logic [1:0]   mode = 2'b00;
  logic         clr = 1'b0;
  logic [N-1:0] led;
  logic         any_sticky;
  int total = 0, bad = 0;
  logic [N-1:0] m_fq, m_st, m_led;
  logic         m_any;
  logic [1:0]   m_prev;
  int           e, idx;

  led_status_dev #(.N_FLAGS(N), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .flags(flags), .mode(mode), .clr(clr),
    .LED(led), .any_sticky(any_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    m_fq = '0; m_st = '0; m_led = '0; m_any = 1'b0; m_prev = 2'b00; e = 0; idx = 0;
  endtask

  // e counts edges since reset release; a tick lands on every TD-th edge
  task automatic step(input logic [N-1:0] f, input logic [1:0] md, input logic c, input string tag);
    logic ph;
    flags = f; mode = md; clr = c;
    @(posedge clk);
    e++;
    ph = ((e - 1) / TD) % 2 == 1;
    if (md == 2'b00)      m_led = m_fq;
    else if (md == 2'b01) m_led = m_st;
    else if (md == 2'b10) m_led = m_fq | (m_st & {N{ph}});
    else begin
      idx   = (m_prev != 2'b11) ? 0 : (e % TD == 0) ? (idx + 1) % N : idx;
      m_led = N'(1) << idx;
    end
    m_any  = |m_st;
    m_st   = (c ? '0 : m_st) | m_fq;
    m_fq   = f;
    m_prev = md;
    #1;
    chk({tag, ".led"}, 32'(led), 32'(m_led));
    chk({tag, ".any"}, 32'(any_sticky), 32'(m_any));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    chk({tag, ".rst_led"}, 32'(led), 32'h0);
    chk({tag, ".rst_any"}, 32'(any_sticky), 32'h0);
    clr = 1'b1;
    flags = '0;
    @(posedge clk);
    #1;
    chk({tag, ".rst_clr_led"}, 32'(led), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    logic hit;
    model_reset();
    do_reset("init");
    // LIVE: two-cycle latency
    step(8'hA5, 2'b00, 1'b0, "live_a");
    step(8'hA5, 2'b00, 1'b0, "live_a");
    chk("live_a5", 32'(led), 32'hA5);
    for (int i = 0; i < 3; i++) step(8'hA5, 2'b00, 1'b0, "live_a");
    for (int i = 0; i < 4; i++) step(8'h00, 2'b00, 1'b0, "live_z");
    chk("live_zero", 32'(led), 32'h0);
    // STICKY capture and clear
    step(8'h00, 2'b01, 1'b1, "st_clr0");
    for (int i = 0; i < 2; i++) step(8'h00, 2'b01, 1'b0, "st_idle");
    step(8'h08, 2'b01, 1'b0, "st_pulse");
    for (int i = 0; i < 3; i++) step(8'h00, 2'b01, 1'b0, "st_hold");
    chk("st_led08", 32'(led), 32'h08);
    chk("st_any1", 32'(any_sticky), 32'h1);
    step(8'h00, 2'b01, 1'b1, "st_clr");
    step(8'h00, 2'b01, 1'b0, "st_after");
    chk("st_led0", 32'(led), 32'h0);
    chk("st_any0", 32'(any_sticky), 32'h0);
    // set wins over clear
    step(8'h02, 2'b01, 1'b0, "pri");
    step(8'h00, 2'b01, 1'b0, "pri");
    step(8'h01, 2'b01, 1'b0, "pri");
    step(8'h01, 2'b01, 1'b1, "pri_clr");
    step(8'h01, 2'b01, 1'b0, "pri");
    step(8'h01, 2'b01, 1'b0, "pri");
    chk("pri_led01", 32'(led), 32'h01);
    // BLINK
    step(8'h00, 2'b01, 1'b1, "bl_clr");
    step(8'h00, 2'b01, 1'b0, "bl_clr");
    step(8'h10, 2'b10, 1'b0, "bl_set");
    for (int i = 0; i < 14; i++) step(8'h00, 2'b10, 1'b0, "bl_blink");
    for (int i = 0; i < 10; i++) step(8'h10, 2'b10, 1'b0, "bl_live");
    chk("bl_steady", 32'(led[4]), 32'h1);
    // SCAN
    step(8'h00, 2'b11, 1'b0, "sc_enter");
    chk("sc_entry01", 32'(led), 32'h01);
    for (int i = 0; i < 40; i++) step(8'h00, 2'b11, 1'b0, "sc_run");
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(8'h00, 2'b11, 1'b0, "sc_seek");
      hit = led == 8'h20;
    end
    chk("sc_seek20", 32'(hit), 32'h1);
    @(negedge clk);
    do_reset("sc_mid");
    step(8'h00, 2'b11, 1'b0, "sc_rel");
    chk("sc_rel01", 32'(led), 32'h01);
    for (int i = 0; i < 12; i++) step(8'h00, 2'b11, 1'b0, "sc_rel_run");
    // randomized traffic with occasional mode changes and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) begin
        @(negedge clk);
        do_reset("rnd_rst");
      end
      step(8'($urandom & $urandom & $urandom), mode, $urandom_range(7) == 0, "rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
